ysyx_24110006_idu_q: RTL and testbench
======================================

Name: ysyx_24110006_idu_q

Overview:
Queued instruction-decode stage, the parametrised successor to the single-register decode latch. It buffers up to DEPTH fetched instructions with their PCs, and uses valid/ready handshakes on both sides instead of the old single-cycle valid pulse. It decodes the head entry combinationally into opcode, funct3, register indices, sign-extended immediate, CSR type and an illegal flag. It sits between the IFU and EXU, and a flush input supports redirect.

Parameters:
DEPTH, 2, number of buffered entries; power of two, at least 1
PC_W, 32, width of the PC carried alongside each instruction
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

Ports:
i_clock  in  1  clock; all state changes on the rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_flush  in  1  discard all buffered entries
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept an entry this cycle
i_inst  in  32  raw instruction
i_pc  in  PC_W  PC of i_inst
o_valid  out  1  head entry valid
i_ready  in  1  downstream accepts the head entry
o_pc  out  PC_W  PC of the head entry
o_op  out  7  inst[6:0]
o_func  out  3  inst[14:12]
o_reg_rd  out  5  inst[11:7]
o_reg_rs1  out  5  inst[19:15]
o_reg_rs2  out  5  inst[24:20]
o_imm  out  32  decoded immediate
o_csr_t  out  2  00 MRET, 01 CSRW, 11 ECALL, 10 NONE
o_illegal  out  1  head opcode is unrecognised (qualified by o_valid)
o_count  out  CNT_W  current occupancy

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - count, read pointer and write pointer go to 0; all entry storage is cleared to 0.
  - Outputs during reset: o_valid=0, o_ready=1, o_count=0, o_illegal=0, o_csr_t=10, o_imm=0, o_pc=0, all field outputs 0.
- Push: i_valid && o_ready. The entry is written at the write pointer, which then increments modulo DEPTH.
- Pop: o_valid && i_ready. The read pointer increments modulo DEPTH.
- o_ready = (count < DEPTH). It is registered state only, with no combinational path from i_ready.
- o_valid = (count != 0). Latency: an entry pushed at edge N appears on o_valid/decode outputs after edge N; this is the minimum one-cycle latency.
- Simultaneous push and pop: count is unchanged. When full, o_ready=0, so no push can occur even if a pop happens in the same cycle.
- Flush has priority over push and pop. On the next edge, count=0 and both pointers are reset to 0. A push or pop in the flush cycle is discarded and has no effect. Storage is not cleared.
- Pointer wrap-around is silent; count never exceeds DEPTH and never underflows.
- Decode is purely combinational from the head entry. Fields are extracted from fixed bit positions.
- Immediate by opcode:
  - I-type (0010011, 1100111, 0000011, 1110011): sign-extended inst[31:20].
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type (1101111): sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - S-type (0100011): sign-extended {inst[31:25], inst[11:7]}.
  - B-type (1100011): sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - R-type (0110011): {25'b0, inst[31:25]}.
  - Any other opcode: 0.
- o_csr_t:
  - Opcode is not 1110011: 10.
  - Opcode is 1110011 with funct3 != 0: 01.
  - Opcode is 1110011 with funct3 == 0: 00 if inst[21]=1, else 11.
- o_illegal = o_valid && opcode not in the ten opcodes listed above.
- When o_valid=0, data outputs reflect the stale head-slot contents; downstream must qualify them with o_valid.

Test Plan:
- Reset mid-stream with 2 entries queued → o_valid=0, o_count=0, o_ready=1, o_csr_t=10 immediately (asynchronous, not waiting for a clock edge).
- Push 0xFFF00093 (addi x1,x0,-1) with i_pc=0x80000000 and i_ready=1 → one cycle later o_valid=1, o_imm=0xFFFFFFFF, o_reg_rd=1, o_op=0x13, o_pc=0x80000000. Next cycle o_valid=0.
- DEPTH=2, i_ready=0, push 0x0020A423 (sw) then 0xFE000EE3 (beq) → o_count=2 and o_ready=0. Head shows o_imm=0x00000008, o_reg_rs2=2. After one pop, head shows o_imm=0xFFFFFFFC. Order is preserved.
- Count=1 with push and pop in the same cycle, repeated 10 cycles across pointer wrap → o_count stays 1 and the PC sequence is in order with no loss.
- Push 0x30200073, 0x00000073, 0x30571073 → o_csr_t is 00, 11, 01 respectively. Push 0x12345037 → o_imm=0x12345000, o_csr_t=10.
- With 2 entries queued, assert i_flush together with i_valid → next cycle o_count=0 and o_valid=0, and the concurrent push is lost. Then push 0x0000007F → o_illegal=1 and o_imm=0.

Source files
------------

// File: rtl/ysyx_24110006_idu_q.sv
// Queued instruction-decode stage between the IFU and the EXU.
// Buffers up to DEPTH instruction/PC pairs behind valid/ready handshakes on
// both sides and decodes the head entry combinationally. A flush drops every
// queued entry so fetch can be redirected.
module ysyx_24110006_idu_q #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [PC_W-1:0]  i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PC_W-1:0]  o_pc,
    output logic [6:0]       o_op,
    output logic [2:0]       o_func,
    output logic [4:0]       o_reg_rd,
    output logic [4:0]       o_reg_rs1,
    output logic [4:0]       o_reg_rs2,
    output logic [31:0]      o_imm,
    output logic [1:0]       o_csr_t,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_count
);

    // A one-entry queue still needs a one-bit pointer to keep the vectors legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] CSR_MRET  = 2'b00;
    localparam logic [1:0] CSR_CSRW  = 2'b01;
    localparam logic [1:0] CSR_NONE  = 2'b10;
    localparam logic [1:0] CSR_ECALL = 2'b11;

    logic [31:0]      inst_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [31:0]      head_inst;
    logic             legal_op;

    // Explicit wrap so non-power-of-two pointer ranges could never walk off the end.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on stored occupancy, so there is no path from i_ready.
    assign o_ready = (count < CNT_MAX);
    assign o_valid = (count != '0);
    assign o_count = count;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    // Queue state: flush beats push/pop and leaves storage untouched.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (i_flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= i_inst;
                pc_mem[wr_ptr]   <= i_pc;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_inst = inst_mem[rd_ptr];
    assign o_pc      = pc_mem[rd_ptr];
    assign o_op      = head_inst[6:0];
    assign o_func    = head_inst[14:12];
    assign o_reg_rd  = head_inst[11:7];
    assign o_reg_rs1 = head_inst[19:15];
    assign o_reg_rs2 = head_inst[24:20];

    // Immediate reassembly and opcode legality, chosen by the head opcode.
    always_comb begin
        o_imm    = '0;
        legal_op = 1'b1;
        unique case (head_inst[6:0])
            OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM:
                o_imm = {{20{head_inst[31]}}, head_inst[31:20]};
            OP_LUI, OP_AUIPC:
                o_imm = {head_inst[31:12], 12'b0};
            OP_JAL:
                o_imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                         head_inst[30:21], 1'b0};
            OP_STORE:
                o_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            OP_BRANCH:
                o_imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                         head_inst[11:8], 1'b0};
            OP_REG:
                o_imm = {25'b0, head_inst[31:25]};
            default: begin
                o_imm    = '0;
                legal_op = 1'b0;
            end
        endcase
    end

    // SYSTEM sub-classification: bit 21 separates MRET from ECALL when funct3 is zero.
    always_comb begin
        o_csr_t = CSR_NONE;
        if (head_inst[6:0] == OP_SYSTEM) begin
            if (head_inst[14:12] != 3'b000) begin
                o_csr_t = CSR_CSRW;
            end else if (head_inst[21]) begin
                o_csr_t = CSR_MRET;
            end else begin
                o_csr_t = CSR_ECALL;
            end
        end
    end

    assign o_illegal = o_valid && !legal_op;

endmodule

// File: tb/tb_ysyx_24110006_idu_q.sv
// Self-checking bench for the queued decode stage: a queue-based reference
// model tracks accepted entries and decodes the head arithmetically.
module tb_ysyx_24110006_idu_q;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             i_clock;
    logic             i_reset_n;
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_inst;
    logic [PC_W-1:0]  i_pc;
    logic             o_valid;
    logic             i_ready;
    logic [PC_W-1:0]  o_pc;
    logic [6:0]       o_op;
    logic [2:0]       o_func;
    logic [4:0]       o_reg_rd;
    logic [4:0]       o_reg_rs1;
    logic [4:0]       o_reg_rs2;
    logic [31:0]      o_imm;
    logic [1:0]       o_csr_t;
    logic             o_illegal;
    logic [CNT_W-1:0] o_count;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t model_q[$];
    int     errors = 0;
    int     checks = 0;

    ysyx_24110006_idu_q #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_inst    (i_inst),
        .i_pc      (i_pc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_pc      (o_pc),
        .o_op      (o_op),
        .o_func    (o_func),
        .o_reg_rd  (o_reg_rd),
        .o_reg_rs1 (o_reg_rs1),
        .o_reg_rs2 (o_reg_rs2),
        .o_imm     (o_imm),
        .o_csr_t   (o_csr_t),
        .o_illegal (o_illegal),
        .o_count   (o_count)
    );

    // Free-running clock, period 10.
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Reference immediate computed with signed shifts on the whole word.
    function automatic logic [31:0] ref_imm(input logic [31:0] inst);
        logic signed [31:0] s;
        logic [31:0]        sign_fill;
        s         = inst;
        sign_fill = 32'(s >>> 31);
        case (inst & 32'h7F)
            32'h13, 32'h67, 32'h03, 32'h73: return 32'(s >>> 20);
            32'h37, 32'h17:                 return inst & 32'hFFFFF000;
            32'h6F: return (sign_fill & 32'hFFF00000) | (32'(inst[19:12]) << 12)
                         | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            32'h23: return (32'(s >>> 25) << 5) | 32'(inst[11:7]);
            32'h63: return (sign_fill & 32'hFFFFF000) | (32'(inst[7]) << 11)
                         | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            32'h33: return inst >> 25;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] ref_csr(input logic [31:0] inst);
        if ((inst & 32'h7F) != 32'h73) return 2'd2;
        if (((inst >> 12) & 32'h7) != 0) return 2'd1;
        return ((inst >> 21) & 32'h1) != 0 ? 2'd0 : 2'd3;
    endfunction

    function automatic bit ref_legal(input logic [31:0] inst);
        int op;
        op = int'(inst & 32'h7F);
        return op inside {'h13, 'h67, 'h03, 'h73, 'h37, 'h17, 'h6F, 'h23, 'h63, 'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every output against the model; data fields only matter when the head is valid.
    task automatic checkOutput(input string tag);
        entry_t head;
        chk({tag, ".count"}, 32'(o_count), 32'(model_q.size()));
        chk({tag, ".valid"}, 32'(o_valid), 32'(model_q.size() != 0));
        chk({tag, ".ready"}, 32'(o_ready), 32'(model_q.size() < DEPTH));
        if (model_q.size() != 0) begin
            head = model_q[0];
            chk({tag, ".pc"},      o_pc,             head.pc);
            chk({tag, ".op"},      32'(o_op),        head.inst & 32'h7F);
            chk({tag, ".func"},    32'(o_func),      (head.inst >> 12) & 32'h7);
            chk({tag, ".rd"},      32'(o_reg_rd),    (head.inst >> 7) & 32'h1F);
            chk({tag, ".rs1"},     32'(o_reg_rs1),   (head.inst >> 15) & 32'h1F);
            chk({tag, ".rs2"},     32'(o_reg_rs2),   (head.inst >> 20) & 32'h1F);
            chk({tag, ".imm"},     o_imm,            ref_imm(head.inst));
            chk({tag, ".csr_t"},   32'(o_csr_t),     32'(ref_csr(head.inst)));
            chk({tag, ".illegal"}, 32'(o_illegal),   32'(!ref_legal(head.inst)));
        end else begin
            chk({tag, ".illegal"}, 32'(o_illegal), 32'h0);
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic ready,
                                 input logic flush, input string tag);
        bit do_push;
        bit do_pop;
        i_valid = valid;
        i_inst  = inst;
        i_pc    = pc;
        i_ready = ready;
        i_flush = flush;
        @(posedge i_clock);
        do_push = valid && (model_q.size() < DEPTH);
        do_pop  = ready && (model_q.size() != 0);
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{inst: inst, pc: pc});
        end
        @(negedge i_clock);
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] pc_base;
        logic [6:0]  ops [11];
        ops = '{7'h13, 7'h67, 7'h03, 7'h73, 7'h37, 7'h17, 7'h6F, 7'h23, 7'h63, 7'h33, 7'h7F};

        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_inst    = '0;
        i_pc      = '0;
        repeat (2) @(negedge i_clock);
        checkOutput("reset");
        chk("reset.csr_t", 32'(o_csr_t), 32'h2);
        chk("reset.imm",   o_imm, 32'h0);
        i_reset_n = 1'b1;

        $display("[TB] addi with immediate pop");
        applyStimulus(1'b1, 32'hFFF00093, 32'h80000000, 1'b1, 1'b0, "addi");
        chk("addi.imm", o_imm, 32'hFFFFFFFF);
        chk("addi.rd",  32'(o_reg_rd), 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "addi_pop");
        chk("addi_pop.valid", 32'(o_valid), 32'h0);

        $display("[TB] fill to full, order preserved");
        applyStimulus(1'b1, 32'h0020A423, 32'h100, 1'b0, 1'b0, "sw");
        applyStimulus(1'b1, 32'hFE000EE3, 32'h104, 1'b0, 1'b0, "beq");
        chk("full.count", 32'(o_count), 32'h2);
        chk("full.ready", 32'(o_ready), 32'h0);
        chk("sw.imm",     o_imm, 32'h8);
        chk("sw.rs2",     32'(o_reg_rs2), 32'h2);
        applyStimulus(1'b1, 32'h00000013, 32'h108, 1'b0, 1'b0, "full_drop");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "pop1");
        chk("beq.imm", o_imm, 32'hFFFFFFFC);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "pop2");

        $display("[TB] steady push+pop across wrap");
        pc_base = 32'h2000;
        applyStimulus(1'b1, 32'h00000013, pc_base, 1'b0, 1'b0, "wrap_seed");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 32'h00000013, pc_base + 32'(i * 4), 1'b1, 1'b0, "wrap");
            chk("wrap.count", 32'(o_count), 32'h1);
            chk("wrap.pc",    o_pc, pc_base + 32'(i * 4));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "wrap_drain");

        $display("[TB] system and lui classification");
        applyStimulus(1'b1, 32'h30200073, 32'h300, 1'b0, 1'b0, "mret");
        chk("mret.csr_t", 32'(o_csr_t), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "mret_pop");
        applyStimulus(1'b1, 32'h00000073, 32'h304, 1'b0, 1'b0, "ecall");
        chk("ecall.csr_t", 32'(o_csr_t), 32'h3);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "ecall_pop");
        applyStimulus(1'b1, 32'h30571073, 32'h308, 1'b0, 1'b0, "csrw");
        chk("csrw.csr_t", 32'(o_csr_t), 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "csrw_pop");
        applyStimulus(1'b1, 32'h12345037, 32'h30C, 1'b0, 1'b0, "lui");
        chk("lui.imm",   o_imm, 32'h12345000);
        chk("lui.csr_t", 32'(o_csr_t), 32'h2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "lui_pop");

        $display("[TB] flush beats concurrent push");
        applyStimulus(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0, "fl_a");
        applyStimulus(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0, "fl_b");
        applyStimulus(1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1, "flush");
        chk("flush.count", 32'(o_count), 32'h0);
        chk("flush.valid", 32'(o_valid), 32'h0);
        applyStimulus(1'b1, 32'h0000007F, 32'h40C, 1'b0, 1'b0, "illegal");
        chk("illegal.flag", 32'(o_illegal), 32'h1);
        chk("illegal.imm",  o_imm, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "illegal_pop");

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0, "ar_a");
        applyStimulus(1'b1, 32'h00600093, 32'h504, 1'b0, 1'b0, "ar_b");
        i_valid   = 1'b0;
        i_reset_n = 1'b0;
        #1;
        model_q.delete();
        checkOutput("async_reset");
        chk("async_reset.csr_t", 32'(o_csr_t), 32'h2);
        chk("async_reset.pc",    o_pc, 32'h0);
        @(negedge i_clock);
        i_reset_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            rnd = {rnd[31:7], ops[$urandom_range(0, 10)]};
            applyStimulus(1'($urandom_range(0, 1)), rnd, $urandom(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                          "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
